piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out shift register with a valid/ready load handshake, a bit counter and framing flags.
- Successor to the per-bit load/shift flip-flop PISO. Adds width and shift-direction parameters, a shift-stall input, back-to-back word streaming and word-boundary signalling.
- Sits between a parallel data source (FIFO or register file) and a serial line driver.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately, with no clock required.
- load_valid  input  1  source presents a word on d_parallel.
- load_ready  output  1  serializer will accept a word this cycle.
- d_parallel  input  WIDTH  parallel word; sampled only on a handshake.
- hold  input  1  1 = freeze shifting this cycle (all state holds).
- q  output  1  serial data bit.
- q_valid  output  1  q carries a data bit this cycle.
- first  output  1  q is the first bit of a word.
- last  output  1  q is the final bit of a word.
- busy  output  1  1 while in SHIFT state.

Behaviour:
- Reset (reset=0, asynchronous), all values 0: state=IDLE, shift register, bit counter, q, q_valid, first, last, busy.
- Reset asserted mid-word: the word is dropped; no partial completion after release.
- First rising clk edge after reset returns to 1 behaves as normal IDLE.
- Handshake: a word transfers on a rising edge where load_valid=1 and load_ready=1. d_parallel is ignored at all other times.
- load_ready is combinational: 1 in IDLE; 1 in SHIFT only when counter==WIDTH-1 and hold=0; otherwise 0.
- States: IDLE, SHIFT.
- IDLE:
  - q=0, q_valid=0, first=0, last=0, busy=0.
  - On handshake: shift register <= d_parallel, counter <= 0, next state SHIFT.
- SHIFT:
  - busy=1, q_valid=1.
  - q = shreg[WIDTH-1] when MSB_FIRST=1, shreg[0] when MSB_FIRST=0. q is taken directly from the register, so no extra output stage.
  - first = (counter==0); last = (counter==WIDTH-1).
  - Latency: the first bit of a word appears on q in the cycle after its handshake edge.
- SHIFT with hold=1: shift register, counter and state all hold. q, first, last keep their values. q_valid stays 1 and the bit is re-presented.
- SHIFT with hold=0 and counter<WIDTH-1:
  - Shift one position toward the output end; vacated bit filled with 0.
  - counter <= counter+1.
- SHIFT with hold=0 and counter==WIDTH-1 (last bit):
  - With handshake: reload from d_parallel, counter <= 0, stay in SHIFT. Back-to-back streaming, no idle gap.
  - Without handshake: go to IDLE. The next cycle has q=0, q_valid=0.
- A word occupies exactly WIDTH non-held SHIFT cycles.
- The counter never exceeds WIDTH-1. No wrap-around is reachable.
- load_valid and hold both 1 on the last bit: no transfer (load_ready=0); the source must keep load_valid asserted.
- load_valid may deassert at any time without a handshake; nothing is lost.
- Outputs are glitch-free registered values, except load_ready, which is combinational from state, counter and hold.

Test Plan:
- Reset: drive reset=0 with clk running, then release → every output 0, load_ready=1. Assert reset=0 between clock edges mid-word → outputs drop to 0 with no clock edge.
- Single word, WIDTH=8, MSB_FIRST=1, d_parallel=8'hA5: one handshake then idle → q = 1,0,1,0,0,1,0,1 on consecutive cycles starting one cycle after the handshake. first on bit 1 only, last on bit 8 only, then q_valid=0.
- LSB-first, MSB_FIRST=0, d_parallel=8'hA5 → q = 1,0,1,0,0,1,0,1 (bit0 first). Also d_parallel=8'h01 → q = 1,0,0,0,0,0,0,0.
- Back-to-back: 8'hF0 then 8'h0F with load_valid held high → 16 consecutive q_valid cycles: 1111000000001111. last then first on adjacent cycles, busy never drops.
- Hold: word 8'hC3, hold=1 for 3 cycles during bit 4 → bit 4 presented 4 cycles, total word 11 cycles, serial pattern unchanged. hold=1 on the last bit with load_valid=1 → load_ready=0, no reload until hold=0.
- Parameter sweep: WIDTH=2 with 2'b10 and WIDTH=32 with 32'hDEADBEEF, both directions → bit order correct, exactly WIDTH q_valid cycles per word.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake.
// It also provides a shift stall, back-to-back word streaming and first/last bit framing.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d_parallel,
  input  logic             hold,
  output logic             q,
  output logic             q_valid,
  output logic             first,
  output logic             last,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam int unsigned      OUT_IDX  = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             active_d;
  logic             q_d;
  logic             first_d;
  logic             last_d;

  // Ready is combinational so the next word can be accepted on the last bit.
  assign load_ready = (state == IDLE) ||
                      ((state == SHIFT) && (cnt == CNT_LAST) && !hold);

  // Next-state, datapath and next output values
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;

    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          shreg_d = d_parallel;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold) begin
          if (cnt == CNT_LAST) begin
            if (load_valid && load_ready) begin
              shreg_d = d_parallel;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            if (MSB_FIRST != 0) shreg_d = {shreg[WIDTH-2:0], 1'b0};
            else                shreg_d = {1'b0, shreg[WIDTH-1:1]};
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave flops directly.
    active_d = (state_d == SHIFT);
    q_d      = active_d && shreg_d[OUT_IDX];
    first_d  = active_d && (cnt_d == '0);
    last_d   = active_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
      q       <= 1'b0;
      q_valid <= 1'b0;
      first   <= 1'b0;
      last    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      cnt     <= cnt_d;
      q       <= q_d;
      q_valid <= active_d;
      first   <= first_d;
      last    <= last_d;
      busy    <= active_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: six instances (8/2/32 bits, both shift orders)
// share the control inputs so every scenario starts from a common reset.
module tb_piso_serializer;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic        hold;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [31:0] d32;

  // Index map: 0=W8 msb, 1=W8 lsb, 2=W2 msb, 3=W2 lsb, 4=W32 msb, 5=W32 lsb
  wire [5:0] rdy_v, q_v, qv_v, first_v, last_v, busy_v;

  int n_tests = 0;
  int n_fail  = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut8m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_v[0]),
    .d_parallel(d8), .hold(hold), .q(q_v[0]), .q_valid(qv_v[0]),
    .first(first_v[0]), .last(last_v[0]), .busy(busy_v[0]));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut8l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_v[1]),
    .d_parallel(d8), .hold(hold), .q(q_v[1]), .q_valid(qv_v[1]),
    .first(first_v[1]), .last(last_v[1]), .busy(busy_v[1]));
  piso_serializer #(.WIDTH(2), .MSB_FIRST(1)) dut2m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_v[2]),
    .d_parallel(d2), .hold(hold), .q(q_v[2]), .q_valid(qv_v[2]),
    .first(first_v[2]), .last(last_v[2]), .busy(busy_v[2]));
  piso_serializer #(.WIDTH(2), .MSB_FIRST(0)) dut2l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_v[3]),
    .d_parallel(d2), .hold(hold), .q(q_v[3]), .q_valid(qv_v[3]),
    .first(first_v[3]), .last(last_v[3]), .busy(busy_v[3]));
  piso_serializer #(.WIDTH(32), .MSB_FIRST(1)) dut32m (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_v[4]),
    .d_parallel(d32), .hold(hold), .q(q_v[4]), .q_valid(qv_v[4]),
    .first(first_v[4]), .last(last_v[4]), .busy(busy_v[4]));
  piso_serializer #(.WIDTH(32), .MSB_FIRST(0)) dut32l (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(rdy_v[5]),
    .d_parallel(d32), .hold(hold), .q(q_v[5]), .q_valid(qv_v[5]),
    .first(first_v[5]), .last(last_v[5]), .busy(busy_v[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load_valid = 1'b0;
    hold       = 1'b0;
    reset      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; load_valid = 1'b0; hold = 1'b0;
    d8 = 8'h00; d2 = 2'b00; d32 = 32'h0;
    repeat (3) tick();
    n_tests++;
    if ({q_v, qv_v, first_v, last_v, busy_v} !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_held outputs got %h want 0", {q_v, qv_v, first_v, last_v, busy_v});
    end
    reset = 1'b1;
    tick();
    n_tests++;
    if ({q_v, qv_v, first_v, last_v, busy_v} !== 30'h0) begin
      n_fail++;
      $display("FAIL reset_released outputs got %h want 0", {q_v, qv_v, first_v, last_v, busy_v});
    end
    n_tests++;
    if (rdy_v !== 6'h3f) begin
      n_fail++;
      $display("FAIL reset_ready got %b want 111111", rdy_v);
    end
  endtask

  task automatic test_single_word();
    int          idx_t[3] = '{0, 1, 1};
    logic [7:0]  dat_t[3] = '{8'hA5, 8'hA5, 8'h01};
    logic [31:0] exp_t[3] = '{32'b10100101, 32'b10100101, 32'b10000000};
    for (int c = 0; c < 3; c++) begin
      int idx = idx_t[c];
      do_reset();
      d8 = dat_t[c];
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
        logic [4:0] expv = {exp_t[c][7-i], 1'b1, (i == 0), (i == 7), 1'b1};
        logic [4:0] obs  = {q_v[idx], qv_v[idx], first_v[idx], last_v[idx], busy_v[idx]};
        n_tests++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL single_word case %0d bit %0d {q,qv,first,last,busy} got %b want %b", c, i, obs, expv);
        end
        n_tests++;
        if (rdy_v[idx] !== (i == 7)) begin
          n_fail++;
          $display("FAIL single_word_ready case %0d bit %0d got %b want %b", c, i, rdy_v[idx], (i == 7));
        end
        tick();
      end
      n_tests++;
      if ({q_v[idx], qv_v[idx], busy_v[idx], rdy_v[idx]} !== 4'b0001) begin
        n_fail++;
        $display("FAIL single_word_end case %0d {q,qv,busy,ready} got %b want 0001", c,
                 {q_v[idx], qv_v[idx], busy_v[idx], rdy_v[idx]});
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_seq = 16'b1111000000001111;
    do_reset();
    d8 = 8'hF0;
    load_valid = 1'b1;
    tick();
    d8 = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      logic [4:0] expv = {exp_seq[15-i], 1'b1, (i == 0 || i == 8), (i == 7 || i == 15), 1'b1};
      logic [4:0] obs  = {q_v[0], qv_v[0], first_v[0], last_v[0], busy_v[0]};
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL back_to_back bit %0d {q,qv,first,last,busy} got %b want %b", i, obs, expv);
      end
      tick();
      if (i == 7) load_valid = 1'b0;
    end
    n_tests++;
    if ({qv_v[0], busy_v[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL back_to_back_end {qv,busy} got %b want 00", {qv_v[0], busy_v[0]});
    end
  endtask

  task automatic test_hold();
    logic [10:0] exp_seq = 11'b11000000011;
    do_reset();
    d8 = 8'hC3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      logic [4:0] expv;
      logic [4:0] obs;
      hold = (i >= 3 && i <= 5);
      #1;
      expv = {exp_seq[10-i], 1'b1, (i == 0), (i == 10), 1'b1};
      obs  = {q_v[0], qv_v[0], first_v[0], last_v[0], busy_v[0]};
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL hold cycle %0d {q,qv,first,last,busy} got %b want %b", i, obs, expv);
      end
      tick();
    end
    hold = 1'b0;
    n_tests++;
    if (qv_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_end q_valid got %b want 0", qv_v[0]);
    end
  endtask

  task automatic test_hold_last();
    do_reset();
    d8 = 8'hC3;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    repeat (7) tick();
    d8 = 8'h81;
    load_valid = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if ({rdy_v[0], q_v[0], qv_v[0], first_v[0], last_v[0]} !== 5'b01101) begin
        n_fail++;
        $display("FAIL hold_last cycle %0d {ready,q,qv,first,last} got %b want 01101", i,
                 {rdy_v[0], q_v[0], qv_v[0], first_v[0], last_v[0]});
      end
      tick();
    end
    hold = 1'b0;
    #1;
    n_tests++;
    if (rdy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_last_release ready got %b want 1", rdy_v[0]);
    end
    tick();
    load_valid = 1'b0;
    n_tests++;
    if ({q_v[0], qv_v[0], first_v[0], last_v[0]} !== 4'b1110) begin
      n_fail++;
      $display("FAIL hold_last_reload {q,qv,first,last} got %b want 1110",
               {q_v[0], qv_v[0], first_v[0], last_v[0]});
    end
    tick();
    n_tests++;
    if ({q_v[0], first_v[0]} !== 2'b00) begin
      n_fail++;
      $display("FAIL hold_last_second_bit {q,first} got %b want 00", {q_v[0], first_v[0]});
    end
  endtask

  task automatic test_param_sweep();
    int          idx_t[4] = '{2, 3, 4, 5};
    int          w_t[4]   = '{2, 2, 32, 32};
    logic [31:0] exp_t[4] = '{32'h2, 32'h1, 32'hDEADBEEF, 32'hF77DB57B};
    for (int c = 0; c < 4; c++) begin
      int idx = idx_t[c];
      int w   = w_t[c];
      do_reset();
      d2  = 2'b10;
      d32 = 32'hDEADBEEF;
      load_valid = 1'b1;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < w; i++) begin
        logic [4:0] expv = {exp_t[c][w-1-i], 1'b1, (i == 0), (i == w - 1), 1'b1};
        logic [4:0] obs  = {q_v[idx], qv_v[idx], first_v[idx], last_v[idx], busy_v[idx]};
        n_tests++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL sweep case %0d bit %0d {q,qv,first,last,busy} got %b want %b", c, i, obs, expv);
        end
        tick();
      end
      n_tests++;
      if ({q_v[idx], qv_v[idx], busy_v[idx]} !== 3'b000) begin
        n_fail++;
        $display("FAIL sweep_end case %0d {q,qv,busy} got %b want 000", c,
                 {q_v[idx], qv_v[idx], busy_v[idx]});
      end
    end
  endtask

  task automatic test_async_reset_midword();
    do_reset();
    d8 = 8'hFF;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({qv_v[0], busy_v[0], q_v[0]} !== 3'b111) begin
      n_fail++;
      $display("FAIL midword_pre {qv,busy,q} got %b want 111", {qv_v[0], busy_v[0], q_v[0]});
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({q_v, qv_v, first_v, last_v, busy_v} !== 30'h0) begin
      n_fail++;
      $display("FAIL midword_async outputs got %h want 0", {q_v, qv_v, first_v, last_v, busy_v});
    end
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({qv_v, busy_v, rdy_v} !== 18'h0003f) begin
        n_fail++;
        $display("FAIL midword_after cycle %0d {qv,busy,ready} got %h want 0003f", i, {qv_v, busy_v, rdy_v});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_hold();
    test_hold_last();
    test_param_sweep();
    test_async_reset_midword();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
